// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module : vga_timing_pkg
// Default 640x480@60 timing constants, pulse bundle type and total helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int DEF_CLK_DIV      = 4;
  localparam int DEF_CNT_W        = 11;
  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_H_FP         = 16;
  localparam int DEF_H_SYNC       = 96;
  localparam int DEF_H_BP         = 48;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_FP         = 10;
  localparam int DEF_V_SYNC       = 2;
  localparam int DEF_V_BP         = 33;
  localparam int DEF_REFRESH_LINE = 481;
  localparam int DEF_FRAME_CNT_W  = 8;

  typedef struct packed {
    logic pix_stb;
    logic line_start;
    logic frame_start;
    logic refresh_tick;
  } vga_pulse_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_pix_div.sv
// ============================================================================
// Module : vga_pix_div
// Pixel strobe divider: o_adv is high one clock in every CLK_DIV clocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_pix_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic o_adv
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] c_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;

  // With CLK_DIV=1 the counter is pinned at zero, so o_adv is high every cycle.
  assign o_adv = (r_div_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (rst || o_adv) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module : vga_timing_gen
// Parametrised VGA raster timing generator on the board clock with pixel strobe.
// Optional: define VGA_FRAME_COUNT_EN to add the frame_count output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter bit H_POL        = 1'b0,
  parameter bit V_POL        = 1'b0,
  parameter int REFRESH_LINE = DEF_REFRESH_LINE,
  parameter int FRAME_CNT_W  = DEF_FRAME_CNT_W
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic             de,
  output logic             pix_stb,
  output logic             line_start,
  output logic             frame_start,
  output logic             refresh_tick
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_count
`endif
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] c_H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] c_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] c_VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] c_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] c_REF_LINE = CNT_W'(REFRESH_LINE);

  if (H_BP < 1 || V_BP < 1 || CLK_DIV < 1 || FRAME_CNT_W < 1 ||
      H_TOTAL - 1 > 2**CNT_W - 1 || V_TOTAL - 1 > 2**CNT_W - 1) begin : g_param_guard
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic             w_adv;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  logic             w_hsync_next;
  logic             w_vsync_next;
  logic             w_blank_next;
  vga_pulse_t       w_pulse_next;

  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_blank;
  vga_pulse_t       r_pulse;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk   (CLK100MHZ),
    .rst   (reset),
    .o_adv (w_adv)
  );

  // Everything is decoded from the next counter value so outputs line up with the counters.
  always_comb begin
    w_h_next = r_hcount;
    w_v_next = r_vcount;
    if (w_adv) begin
      if (r_hcount == c_H_LAST) begin
        w_h_next = '0;
        w_v_next = (r_vcount == c_V_LAST) ? '0 : r_vcount + CNT_W'(1);
      end else begin
        w_h_next = r_hcount + CNT_W'(1);
      end
    end
    w_blank_next = (w_h_next >= c_H_ACT) || (w_v_next >= c_V_ACT);
    w_hsync_next = ((w_h_next >= c_HS_BEG) && (w_h_next < c_HS_END)) ? H_POL : ~H_POL;
    w_vsync_next = ((w_v_next >= c_VS_BEG) && (w_v_next < c_VS_END)) ? V_POL : ~V_POL;
    w_pulse_next.pix_stb      = w_adv;
    w_pulse_next.line_start   = w_adv && (w_h_next == '0);
    w_pulse_next.frame_start  = w_adv && (w_h_next == '0) && (w_v_next == '0);
    w_pulse_next.refresh_tick = w_adv && (w_h_next == '0) && (w_v_next == c_REF_LINE);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_hcount <= c_H_LAST;
      r_vcount <= c_V_LAST;
      r_hsync  <= ~H_POL;
      r_vsync  <= ~V_POL;
      r_blank  <= 1'b1;
      r_pulse  <= '0;
    end else begin
      r_hcount <= w_h_next;
      r_vcount <= w_v_next;
      r_hsync  <= w_hsync_next;
      r_vsync  <= w_vsync_next;
      r_blank  <= w_blank_next;
      r_pulse  <= w_pulse_next;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_count;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_frame_count <= '0;
    end else if (w_pulse_next.frame_start) begin
      r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
    end
  end

  assign frame_count = r_frame_count;
`else
  // Frame counter not built in this configuration.
`endif

  assign hcount       = r_hcount;
  assign vcount       = r_vcount;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign blank        = r_blank;
  assign de           = ~r_blank;
  assign pix_stb      = r_pulse.pix_stb;
  assign line_start   = r_pulse.line_start;
  assign frame_start  = r_pulse.frame_start;
  assign refresh_tick = r_pulse.refresh_tick;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module : tb_vga_timing_gen
// Scoreboard bench: raster position derived arithmetically from clocks since reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  localparam int DIV  = 3;
  localparam int CW   = 5;
  localparam int HA   = 8;
  localparam int HFP  = 2;
  localparam int HS   = 3;
  localparam int HBP  = 2;
  localparam int VA   = 6;
  localparam int VFP  = 1;
  localparam int VS   = 2;
  localparam int VBP  = 1;
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b0;
  localparam int REF  = 7;
  localparam int FCW  = 2;
  localparam int HT   = HA + HFP + HS + HBP;
  localparam int VT   = VA + VFP + VS + VBP;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] hcount, vcount;
  logic          hsync, vsync, blank, de, pix_stb, line_start, frame_start, refresh_tick;
`ifdef VGA_FRAME_COUNT_EN
  logic [FCW-1:0] frame_count;
`endif

  vga_timing_gen #(
    .CLK_DIV(DIV), .CNT_W(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .H_POL(HPOL), .V_POL(VPOL),
    .REFRESH_LINE(REF), .FRAME_CNT_W(FCW)
  ) dut (
    .CLK100MHZ(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank), .de(de), .pix_stb(pix_stb),
    .line_start(line_start), .frame_start(frame_start), .refresh_tick(refresh_tick)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int h; int v; int fc;
    bit hs; bit vs; bit blank; bit pix; bit ls; bit fs; bit rt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   frames_seen = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // n = clocks since the last reset edge; every DIV clocks the raster steps one pixel.
  function automatic exp_t model(input longint n);
    exp_t   e;
    longint p, q;
    p = n / DIV;
    if (p == 0) begin
      e.h = HT - 1; e.v = VT - 1; e.fc = 0;
      e.blank = 1'b1; e.hs = !HPOL; e.vs = !VPOL;
      e.pix = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.rt = 1'b0;
    end else begin
      q     = p - 1;
      e.h   = int'(q % HT);
      e.v   = int'((q / HT) % VT);
      e.fc  = int'(((q / (HT * VT)) + 1) % (1 << FCW));
      e.blank = (e.h >= HA) || (e.v >= VA);
      e.hs  = (e.h >= HA + HFP && e.h < HA + HFP + HS) ? HPOL : !HPOL;
      e.vs  = (e.v >= VA + VFP && e.v < VA + VFP + VS) ? VPOL : !VPOL;
      e.pix = (n % DIV == 0);
      e.ls  = e.pix && (e.h == 0);
      e.fs  = e.ls && (e.v == 0);
      e.rt  = e.ls && (e.v == REF);
    end
    return e;
  endfunction

  // Reference model: one expected output set per clock edge once reset has been seen.
  initial begin
    longint n = 0;
    bit     started = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        n = 0;
        started = 1;
      end else if (started) begin
        n++;
      end
      if (started) exp_q.push_back(model(n));
    end
  end

  // Monitor: outputs are valid every clock, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hcount", int'(hcount), e.h);
        chk("vcount", int'(vcount), e.v);
        chk("hsync", int'(hsync), int'(e.hs));
        chk("vsync", int'(vsync), int'(e.vs));
        chk("blank", int'(blank), int'(e.blank));
        chk("de", int'(de), int'(!e.blank));
        chk("pix_stb", int'(pix_stb), int'(e.pix));
        chk("line_start", int'(line_start), int'(e.ls));
        chk("frame_start", int'(frame_start), int'(e.fs));
        chk("refresh_tick", int'(refresh_tick), int'(e.rt));
`ifdef VGA_FRAME_COUNT_EN
        chk("frame_count", int'(frame_count), e.fc);
`endif
        if (frame_start === 1'b1) frames_seen++;
      end
    end
  end

  // Stimulus: clean start, directed mid-line reset, then random reset bursts.
  initial begin
    int  hold;
    bit  found;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (1000) @(negedge clk);

    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (hcount == CW'(5) && vcount == CW'(3)) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_pos(5,3): got timeout expected position reached");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (600) @(negedge clk);

    hold = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (hold > 0) begin
        hold--;
        if (hold == 0) reset = 1'b0;
      end else if ($urandom_range(0, 1499) == 0) begin
        reset = 1'b1;
        hold  = $urandom_range(1, 3);
      end
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);

    checks++;
    if (frames_seen < 3) begin
      failures++;
      $display("FAIL frames_seen: got %0d expected at least 3", frames_seen);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
